// File: rtl/branch_hazard_scoreboard.sv
// Register-countdown scoreboard that holds ID-stage branches and load-use
// consumers until their producers reach a stage the ID comparator can
// forward from.

// One register's countdown. A fresh issue reloads it; otherwise it drains
// toward zero. Everything freezes while the back end is held.
module bhs_reg_cnt #(
  parameter int CNT_W    = 2,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hold,
  input  logic             i_set,
  input  logic             i_set_load,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_nz_nxt
);
  localparam logic [CNT_W-1:0] ALU_V  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0] cnt_nxt;

  // Next value: the youngest writer overrides any older pending countdown.
  always_comb begin
    cnt_nxt = o_cnt;
    if (!i_hold) begin
      if (i_set)             cnt_nxt = i_set_load ? LOAD_V : ALU_V;
      else if (o_cnt != '0)  cnt_nxt = o_cnt - 1'b1;
    end
  end

  assign o_nz_nxt = (cnt_nxt != '0);

  // Countdown state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_cnt <= '0;
    else          o_cnt <= cnt_nxt;
  end
endmodule

module branch_hazard_scoreboard #(
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  input  logic        i_issue_reg_write,
  input  logic        i_issue_is_load,
  input  logic        i_hold,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic        i_id_is_branch,
  output logic        o_stall,
  output logic        o_busy_rs1,
  output logic        o_busy_rs2,
  output logic [5:0]  o_pending,
  output logic [15:0] o_stall_count
);
  localparam int NUM_REGS = 32;
  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_LAT);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
  } issue_req_t;

  issue_req_t                          iss;
  logic [NUM_REGS-1:0][CNT_W-1:0]      cnt;
  logic [NUM_REGS-1:0]                 nz_nxt;
  logic [CNT_W-1:0]                    cnt_a, cnt_b;
  logic                                busy_a, busy_b, lu_a, lu_b;
  logic [5:0]                          pend_nxt;

  assign iss = '{valid: i_issue_valid, rd: i_issue_rd,
                 reg_write: i_issue_reg_write, is_load: i_issue_is_load};

  // x0 is hardwired: never busy, no storage.
  assign cnt[0]    = '0;
  assign nz_nxt[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_reg
      bhs_reg_cnt #(.CNT_W(CNT_W), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT)) u_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_hold     (i_hold),
        .i_set      (iss.valid && iss.reg_write && (iss.rd == 5'(r))),
        .i_set_load (iss.is_load),
        .o_cnt      (cnt[r]),
        .o_nz_nxt   (nz_nxt[r])
      );
    end
  endgenerate

  // Lookup uses registered state only; a same-cycle issue is not visible.
  always_comb begin
    cnt_a   = cnt[i_id_rs1];
    cnt_b   = cnt[i_id_rs2];
    busy_a  = i_id_uses_rs1 && (cnt_a != '0);
    busy_b  = i_id_uses_rs2 && (cnt_b != '0);
    lu_a    = i_id_uses_rs1 && (cnt_a == LOAD_V);
    lu_b    = i_id_uses_rs2 && (cnt_b == LOAD_V);
    o_stall = i_id_is_branch ? (busy_a || busy_b) : (lu_a || lu_b);
  end

  assign o_busy_rs1 = (cnt_a != '0);
  assign o_busy_rs2 = (cnt_b != '0);

  // Population count of next-state nonzero counters so o_pending tracks cnt.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) pend_nxt = pend_nxt + {5'd0, nz_nxt[i]};
  end

  // Registered pending count and saturating stall-cycle counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pending     <= '0;
      o_stall_count <= '0;
    end else begin
      o_pending <= pend_nxt;
      if (o_stall && (o_stall_count != 16'hFFFF)) o_stall_count <= o_stall_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_hazard_scoreboard.sv
module tb_branch_hazard_scoreboard;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_reg_write, issue_is_load, hold;
  logic [4:0]  issue_rd, id_rs1, id_rs2;
  logic        id_uses_rs1, id_uses_rs2, id_is_branch;
  logic        stall, busy_rs1, busy_rs2;
  logic [5:0]  pending;
  logic [15:0] stall_count;

  branch_hazard_scoreboard #(.ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .CNT_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_issue_reg_write(issue_reg_write), .i_issue_is_load(issue_is_load),
    .i_hold(hold), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
    .i_id_is_branch(id_is_branch),
    .o_stall(stall), .o_busy_rs1(busy_rs1), .o_busy_rs2(busy_rs2),
    .o_pending(pending), .o_stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference: cycles remaining until each register's value is forwardable.
  int m_left[32];
  int m_sc;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pending();
    int n = 0;
    for (int i = 1; i < 32; i++) if (m_left[i] > 0) n++;
    return n;
  endfunction

  function automatic bit m_stall(input bit br, input bit u1, input int r1, input bit u2, input int r2);
    if (br) return (u1 && m_left[r1] > 0) || (u2 && m_left[r2] > 0);
    return (u1 && m_left[r1] == LOAD_LAT) || (u2 && m_left[r2] == LOAD_LAT);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_left[i] = 0;
    m_sc = 0;
  endtask

  // One cycle: drive at posedge+1, check combinational mid-cycle, advance
  // the model on the edge, check registered outputs just after it.
  task automatic step(input bit iv, input int rd, input bit rw, input bit ld, input bit hd,
                      input bit br, input bit u1, input int r1, input bit u2, input int r2);
    bit es;
    es = m_stall(br, u1, r1, u2, r2);
    issue_valid = es ? 1'b0 : iv;
    issue_rd = 5'(rd); issue_reg_write = rw; issue_is_load = ld; hold = hd;
    id_is_branch = br; id_uses_rs1 = u1; id_rs1 = 5'(r1); id_uses_rs2 = u2; id_rs2 = 5'(r2);
    #3;
    chk("stall", {31'd0, stall}, {31'd0, es});
    chk("busy_rs1", {31'd0, busy_rs1}, {31'd0, m_left[r1] > 0});
    chk("busy_rs2", {31'd0, busy_rs2}, {31'd0, m_left[r2] > 0});
    @(posedge clk);
    if (!hd) begin
      for (int i = 1; i < 32; i++) begin
        if (!es && iv && rw && rd == i) m_left[i] = ld ? LOAD_LAT : ALU_LAT;
        else if (m_left[i] > 0) m_left[i]--;
      end
    end
    if (es && m_sc < 65535) m_sc++;
    #1;
    chk("pending", {26'd0, pending}, 32'(m_pending()));
    chk("stall_count", {16'd0, stall_count}, 32'(m_sc));
  endtask

  task automatic idle(input bit br, input bit u1, input int r1, input bit u2, input int r2);
    step(0, 0, 0, 0, 0, br, u1, r1, u2, r2);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    issue_valid = 0; issue_rd = 0; issue_reg_write = 0; issue_is_load = 0; hold = 0;
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_branch = 0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", {26'd0, pending}, 32'd0);
    chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
    rst_n = 1'b1;

    // ALU producer -> dependent branch: one stall cycle
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 1, 5, 0, 0);
    idle(1, 1, 5, 0, 0);

    // Load producer -> branch: two stalls; -> non-branch user: one stall
    step(1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 1, 7);
    idle(1, 0, 0, 1, 7);
    idle(1, 0, 0, 1, 7);
    step(1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 1, 7);
    idle(0, 0, 0, 1, 7);

    // WAW: younger ALU write to x3 shortens the countdown
    step(1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 1, 3, 0, 0);
    idle(1, 1, 3, 0, 0);

    // x0 and non-writing issues leave no trace
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 6, 0, 1, 0, 1, 1, 0, 1, 0);
    idle(1, 1, 0, 1, 6);

    // Hold freezes the countdown; five stall cycles in total
    base = m_sc;
    step(1, 9, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 12, 1, 0, 1, 1, 1, 9, 0, 0);
    repeat (3) idle(1, 1, 9, 0, 0);
    chk("hold_stall_cycles", 32'(stall_count) - 32'(base), 32'd5);

    // Randomized traffic over a small register window to force collisions
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), $urandom_range(0, 7) == 0,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 7));
    end

    // Async reset mid-countdown clears outputs before any edge
    step(1, 4, 1, 1, 0, 0, 0, 0, 0, 0);
    id_is_branch = 1; id_uses_rs1 = 1; id_rs1 = 5'd4;
    #1 rst_n = 1'b0;
    #1;
    m_clear();
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_rs1}, 32'd0);
    chk("rst_mid_pending", {26'd0, pending}, 32'd0);
    chk("rst_mid_stall_count", {16'd0, stall_count}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1, 1, 4, 0, 0);

    // Saturation: hold a stalled branch for 70000 cycles
    step(1, 10, 1, 1, 0, 0, 0, 0, 0, 0);
    issue_valid = 0; hold = 1; id_is_branch = 1; id_uses_rs1 = 1; id_rs1 = 5'd10;
    id_uses_rs2 = 0;
    repeat (70000) @(posedge clk);
    #1;
    m_sc = (m_sc + 70000 > 65535) ? 65535 : m_sc + 70000;
    chk("sat_stall_count", {16'd0, stall_count}, 32'hFFFF);
    chk("sat_model", {16'd0, stall_count}, 32'(m_sc));
    repeat (2) step(0, 0, 0, 0, 1, 1, 1, 10, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_hazard_scoreboard.md
# branch_hazard_scoreboard

Producer-side companion to the ID-stage branch forwarding logic. Tracks, per architectural register, how many cycles remain until an in-flight result reaches a stage the ID-stage branch comparator can forward from (EX/MEM or MEM/WB). Asserts a stall to the hazard controller when the ID instruction would otherwise compare stale or not-yet-produced data. Sits beside the ID/EX pipeline register; updated when an instruction issues from ID into EX.

## Interface

Parameters:
- ALU_LAT, 1, cycles after issue until an ALU/JAL result is forwardable to ID (from EX/MEM)
- LOAD_LAT, 2, cycles after issue until a load result is forwardable to ID (from MEM/WB)
- CNT_W, 2, width of each per-register countdown; must hold max(ALU_LAT, LOAD_LAT)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_issue_valid  in  1  an instruction leaves ID into EX this cycle
- i_issue_rd  in  5  destination register of the issuing instruction
- i_issue_reg_write  in  1  issuing instruction writes rd
- i_issue_is_load  in  1  issuing instruction is a load
- i_hold  in  1  downstream pipeline frozen (EX/MEM/WB do not advance)
- i_id_rs1  in  5  ID-stage source register 1
- i_id_rs2  in  5  ID-stage source register 2
- i_id_uses_rs1  in  1  ID instruction reads rs1
- i_id_uses_rs2  in  1  ID instruction reads rs2
- i_id_is_branch  in  1  ID instruction is a conditional branch (compared in ID)
- o_stall  out  1  hold ID/IF and inject a bubble into EX
- o_busy_rs1  out  1  rs1 countdown nonzero
- o_busy_rs2  out  1  rs2 countdown nonzero
- o_pending  out  6  number of registers with nonzero countdown (0..31)
- o_stall_count  out  16  saturating count of cycles with o_stall=1

## Operation

- State: cnt[1..31], CNT_W bits each; x0 has no storage, always reads 0.
- Per clock edge with i_hold=0, for each register r:
  - if i_issue_valid && i_issue_reg_write && i_issue_rd==r && r!=0: cnt[r] <= i_issue_is_load ? LOAD_LAT : ALU_LAT (issue wins over decrement, overwrites any older pending value — WAW, youngest writer governs);
  - else if cnt[r]!=0: cnt[r] <= cnt[r]-1;
  - else unchanged.
- i_hold=1: all cnt frozen; issue ignored; o_stall_count still counts if o_stall=1.
- Lookup (combinational from registered cnt, never from same-cycle issue):
  - busy_a = i_id_uses_rs1 && cnt[i_id_rs1]!=0; busy_b likewise for rs2.
  - Branch in ID: o_stall = busy_a || busy_b.
  - Non-branch in ID: o_stall = (uses_rs1 && cnt[rs1]==LOAD_LAT) || (uses_rs2 && cnt[rs2]==LOAD_LAT) (load-use only; EX forwarding covers the rest).
  - o_busy_rs1/o_busy_rs2 ignore i_id_uses_*; raw cnt!=0.
- o_pending: registered population count of nonzero cnt, updated with the state.
- o_stall_count: +1 per edge with o_stall=1; saturates at 16'hFFFF.
- Pipeline contract: while o_stall=1 the pipeline drives i_issue_valid=0.

## Timing

- Reset (i_rst_n low, async): all cnt=0, o_pending=0, o_stall_count=0; therefore o_stall=0, o_busy_rs1/rs2=0 combinationally. Reset mid-countdown clears immediately, no residual stall.
- Issue at edge N: visible to lookup from cycle N+1; ALU producer stalls a dependent branch exactly 1 cycle, load producer exactly 2 cycles, load-use for non-branch exactly 1 cycle.
- o_stall, o_busy_*: zero-cycle combinational from state and ID inputs.
- o_pending, o_stall_count: registered, 1-cycle latency.
- Simultaneous issue to rd==rs being looked up: lookup uses pre-edge value.
- Issue with rd=0 or reg_write=0: no state change.

## Test plan

- Reset: hold i_rst_n=0 with cnt previously loaded -> o_stall=0, o_pending=0, o_stall_count=0 immediately, before any clock edge.
- ALU→branch: issue rd=5 ALU, next cycle ID branch rs1=5 -> o_stall=1 for 1 cycle, then 0; o_pending 1→0.
- Load→branch: issue load rd=7, ID branch rs2=7 -> o_stall=1 for 2 cycles; same with non-branch user -> o_stall=1 for 1 cycle.
- WAW/x0: issue load rd=3 then ALU rd=3 next cycle -> cnt[3]=1, branch on x3 stalls 1 more cycle; issue rd=0 -> o_pending unchanged, no stall on rs=0.
- Hold: load rd=9, assert i_hold 3 cycles -> o_stall stays 1 through hold plus 2 cycles after release; o_stall_count=5.
- Saturation: force continuous stall for 70000 cycles -> o_stall_count=16'hFFFF, stays there.
